pbox_decrypt_core: RTL and testbench

Iterative multi-round decryptor for the team's 32-bit permutation cipher. It undoes the encryption rounds `s = P(s) ^ K_r` by applying `s = Pinv(s ^ K_r)` in reverse round order, one round per clock. It uses a valid/ready handshake on both sides and sits on the receive path, downstream of the link, feeding plaintext words to the consumer.

---
 rtl/pbox_decrypt_core_pkg.sv | 36 +++
 rtl/pbox_decrypt_core_if.sv | 26 ++
 rtl/pbox_decrypt_core_inv_pbox.sv | 19 +
 rtl/pbox_decrypt_core.sv | 97 +++++++++
 tb/tb_pbox_decrypt_core.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pbox_decrypt_core_pkg.sv
// -----------------------------------------------------------------------------
// spn_pkg
// Shared definitions for the 32-bit permutation cipher:
//   ROUNDS_DEFAULT - default round count for encryptor/decryptor cores
//   INV_PBOX       - inverse P-box, Pinv(x)[j] = x[INV_PBOX[j]]
//   FWD_PBOX       - forward P-box, P(y)[i]   = y[FWD_PBOX[i]]
//   fsm_e          - control FSM encoding shared by the cipher cores
//   rotl32         - 32-bit rotate-left used for round-key derivation
// -----------------------------------------------------------------------------
package spn_pkg;

   localparam int ROUNDS_DEFAULT = 8;

   localparam int unsigned INV_PBOX [32] = '{
      11, 17,  5, 27, 25, 10, 20,  0, 13, 21,  3, 28, 29,  7, 18, 24,
      31, 22, 12,  6, 26,  2, 16,  8, 14, 30,  4, 19,  1,  9, 15, 23
   };

   // Inverse mapping of INV_PBOX, so that INV_PBOX[FWD_PBOX[i]] == i.
   localparam int unsigned FWD_PBOX [32] = '{
       7, 28, 21, 10, 26,  2, 19, 13, 23, 29,  5,  0, 18,  8, 24, 30,
      22,  1, 14, 27,  6,  9, 17, 31, 15,  4, 20,  3, 11, 12, 25, 16
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_e;

   // A right shift by 32 yields zero, so r == 0 returns x unchanged.
   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] r);
      return (x << r) | (x >> (6'd32 - {1'b0, r}));
   endfunction

endpackage

// File: rtl/pbox_decrypt_core_if.sv
// -----------------------------------------------------------------------------
// pbox_decrypt_core_if
// Valid/ready bus for the decryptor: ciphertext+key in, plaintext out.
//   in_valid/in_ready/in_data/in_key    - input handshake (producer -> core)
//   out_valid/out_ready/out_data        - output handshake (core -> consumer)
// master: producer/consumer side; slave: the core.
// -----------------------------------------------------------------------------
interface pbox_decrypt_core_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport master (
      output in_valid, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pbox_decrypt_core_inv_pbox.sv
// -----------------------------------------------------------------------------
// inv_pbox
// Purely combinational inverse P-box wiring.
//   x_i - 32-bit input word
//   y_o - Pinv(x_i), y_o[j] = x_i[INV_PBOX[j]]
// -----------------------------------------------------------------------------
module inv_pbox
   import spn_pkg::*;
(
   input  logic [31:0] x_i,
   output logic [31:0] y_o
);

   for (genvar j = 0; j < 32; j++) begin : g_bit
      localparam logic [4:0] SRC = 5'(INV_PBOX[j]);
      assign y_o[j] = x_i[SRC];
   end

endmodule

// File: rtl/pbox_decrypt_core.sv
// -----------------------------------------------------------------------------
// pbox_decrypt_core
// Iterative decryptor: one round s = Pinv(s ^ rotl(key, r)) per clock,
// r counting down from ROUNDS-1 to 0.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of pbox_decrypt_core_if (input/output handshakes)
//   busy  - high while a word is being decrypted or waiting to be taken
// -----------------------------------------------------------------------------
module pbox_decrypt_core
   import spn_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEFAULT
)(
   input  logic                  clk,
   input  logic                  rst_n,
   pbox_decrypt_core_if.slave    bus,
   output logic                  busy
);

   localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   fsm_e          fsm_q;
   logic [31:0]   state_q;
   logic [31:0]   key_q;
   logic [RW-1:0] round_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          busy_q;

   logic [31:0]   mix;
   logic [31:0]   state_d;

   assign mix = state_q ^ rotl32(key_q, 5'(round_q));

   inv_pbox u_inv_pbox (
      .x_i (mix),
      .y_o (state_d)
   );

   // Handshake flags are registered alongside the state, so they change
   // only on a clock edge and never depend combinationally on inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= ST_IDLE;
         state_q     <= '0;
         key_q       <= '0;
         round_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  state_q    <= bus.in_data;
                  key_q      <= bus.in_key;
                  round_q    <= RW'(ROUNDS - 1);
                  fsm_q      <= ST_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_RUN: begin
               state_q <= state_d;
               if (round_q == '0) begin
                  fsm_q       <= ST_DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  round_q <= round_q - 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  fsm_q       <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               fsm_q       <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   // Intermediate round values stay hidden; only a finished word is visible.
   assign bus.out_data  = out_valid_q ? state_q : 32'h0;
   assign busy          = busy_q;

endmodule

// File: tb/tb_pbox_decrypt_core.sv
module tb_pbox_decrypt_core;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pbox_decrypt_core_if if1 ();
   pbox_decrypt_core_if if8 ();
   logic busy1, busy8;

   pbox_decrypt_core #(.ROUNDS(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1),
      .busy  (busy1)
   );

   pbox_decrypt_core #(.ROUNDS(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8),
      .busy  (busy8)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Cipher reference: Pinv(x)[j] = x[Q[j]]; forward P scatters y[j] to bit Q[j].
   int unsigned Q [32] = '{
      11, 17,  5, 27, 25, 10, 20,  0, 13, 21,  3, 28, 29,  7, 18, 24,
      31, 22, 12,  6, 26,  2, 16,  8, 14, 30,  4, 19,  1,  9, 15, 23
   };

   function automatic logic [31:0] m_rotl(input logic [31:0] x, input int r);
      logic [31:0] v = x;
      for (int i = 0; i < r; i++) v = {v[30:0], v[31]};
      return v;
   endfunction

   function automatic logic [31:0] m_pinv(input logic [31:0] x);
      logic [31:0] y = '0;
      for (int j = 0; j < 32; j++) y[j] = x[Q[j]];
      return y;
   endfunction

   function automatic logic [31:0] m_pfwd(input logic [31:0] x);
      logic [31:0] y = '0;
      for (int j = 0; j < 32; j++) y[Q[j]] = x[j];
      return y;
   endfunction

   function automatic logic [31:0] m_encrypt(input logic [31:0] pt, input logic [31:0] key, input int rounds);
      logic [31:0] s = pt;
      for (int r = 0; r < rounds; r++) s = m_pfwd(s) ^ m_rotl(key, r);
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
      end
   endtask

   // One full transaction on DUT 'which' (0: ROUNDS=1, 1: ROUNDS=8) with out_ready high.
   task automatic xact(input int which, input logic [31:0] ct, input logic [31:0] key,
                       input logic [31:0] exp, input string tag);
      int c = 0;
      int lat = (which != 0) ? 8 : 1;
      chk({tag, " in_ready"}, (which != 0) ? if8.in_ready : if1.in_ready, 32'd1);
      if (which != 0) begin
         if8.in_valid = 1'b1; if8.in_data = ct; if8.in_key = key;
      end else begin
         if1.in_valid = 1'b1; if1.in_data = ct; if1.in_key = key;
      end
      @(posedge clk); #1;
      if (which != 0) begin
         if8.in_valid = 1'b0; if8.in_data = $urandom; if8.in_key = $urandom;
      end else begin
         if1.in_valid = 1'b0; if1.in_data = $urandom; if1.in_key = $urandom;
      end
      while (!((which != 0) ? if8.out_valid : if1.out_valid) && c < 40) begin
         @(posedge clk); #1;
         c++;
      end
      chk({tag, " latency"}, c, lat);
      chk({tag, " data"}, (which != 0) ? if8.out_data : if1.out_data, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] pt, key, ct, held;
      int c;

      if1.in_valid = 1'b0; if1.in_data = '0; if1.in_key = '0; if1.out_ready = 1'b1;
      if8.in_valid = 1'b0; if8.in_data = '0; if8.in_key = '0; if8.out_ready = 1'b1;

      // Reset state
      #1;
      chk("rst out_valid8", if8.out_valid, 32'd0);
      chk("rst out_data8", if8.out_data, 32'h0);
      chk("rst busy8", busy8, 32'd0);
      chk("rst busy1", busy1, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("post-rst in_ready8", if8.in_ready, 32'd1);
      chk("post-rst in_ready1", if1.in_ready, 32'd1);

      // ROUNDS=1 directed
      xact(0, 32'h0000_0001, 32'h0, 32'h0000_0080, "r1 single-bit");
      xact(0, 32'h0000_0001, 32'h0000_0001, 32'h0, "r1 key-cancel");
      for (int i = 0; i < 20; i++) begin
         pt = $urandom; key = $urandom;
         xact(0, m_encrypt(pt, key, 1), key, pt, "r1 roundtrip");
      end

      // ROUNDS=8 edge patterns
      xact(1, 32'h0, 32'h0, 32'h0, "r8 all-zero");
      xact(1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, "r8 all-one");

      // ROUNDS=8 random round trips
      for (int i = 0; i < 1000; i++) begin
         pt = $urandom; key = $urandom;
         xact(1, m_encrypt(pt, key, 8), key, pt, "r8 roundtrip");
      end

      // Backpressure in DONE
      pt = $urandom; key = $urandom; ct = m_encrypt(pt, key, 8);
      if8.out_ready = 1'b0;
      chk("bp in_ready", if8.in_ready, 32'd1);
      if8.in_valid = 1'b1; if8.in_data = ct; if8.in_key = key;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      c = 0;
      while (!if8.out_valid && c < 40) begin
         @(posedge clk); #1;
         c++;
      end
      chk("bp latency", c, 32'd8);
      held = pt;
      for (int i = 0; i < 20; i++) begin
         if8.in_valid = i[0]; if8.in_data = $urandom; if8.in_key = $urandom;
         @(posedge clk); #1;
         chk("bp out_valid", if8.out_valid, 32'd1);
         chk("bp out_data", if8.out_data, held);
         chk("bp in_ready", if8.in_ready, 32'd0);
         chk("bp busy", busy8, 32'd1);
      end
      if8.in_valid = 1'b0;
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release in_ready", if8.in_ready, 32'd1);
      chk("bp release out_valid", if8.out_valid, 32'd0);
      chk("bp release busy", busy8, 32'd0);
      pt = $urandom; key = $urandom;
      xact(1, m_encrypt(pt, key, 8), key, pt, "after bp");

      // Reset in the middle of RUN
      pt = $urandom; key = $urandom;
      if8.in_valid = 1'b1; if8.in_data = m_encrypt(pt, key, 8); if8.in_key = key;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("midrun busy", busy8, 32'd1);
      chk("midrun out_valid", if8.out_valid, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", if8.out_valid, 32'd0);
      chk("midrst busy", busy8, 32'd0);
      chk("midrst out_data", if8.out_data, 32'h0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst in_ready", if8.in_ready, 32'd1);
      chk("midrst still no valid", if8.out_valid, 32'd0);
      pt = $urandom; key = $urandom;
      xact(1, m_encrypt(pt, key, 8), key, pt, "after midrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
